// File: rtl/restoring_div16.sv
// restoring_div16: sequential unsigned restoring divider, one quotient bit per clock.
// Keeps the previous result stable on Q/R/dz while a new division runs.
`default_nettype none
`timescale 1ns/1ps

module restoring_div16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             ready,
  output logic             done,
  output logic             dz
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_CALC = 1'b1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] qs_q, qs_d;
  logic [WIDTH-1:0] bs_q, bs_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dzn_q, dzn_d;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             dz_q, done_q;

  logic             w_load;
  logic             w_iter;
  logic             w_last;
  logic [WIDTH:0]   w_trial;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)           state_d = S_CALC;
      S_CALC:  if (cnt_q == C_LAST) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    w_load = 1'b0;
    w_iter = 1'b0;
    w_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready  = 1'b1;
        w_load = start;
      end
      S_CALC: begin
        w_iter = 1'b1;
        w_last = (cnt_q == C_LAST);
      end
      default: ready = 1'b1;
    endcase
  end

  // ------------------------------------------------------------ datapath
  // The partial remainder never exceeds the divisor, so its MSB above
  // WIDTH bits is always zero and is not stored; the trial keeps it.
  assign w_trial = {p_q, qs_q[WIDTH-1]} - {1'b0, bs_q};

  always_comb begin
    qs_d  = qs_q;
    bs_d  = bs_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    dzn_d = dzn_q;
    if (w_load) begin
      qs_d  = A;
      bs_d  = B;
      p_d   = '0;
      cnt_d = '0;
      dzn_d = (B == '0);
    end else if (w_iter) begin
      if (!w_trial[WIDTH]) begin
        p_d  = w_trial[WIDTH-1:0];
        qs_d = {qs_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d  = {p_q[WIDTH-2:0], qs_q[WIDTH-1]};
        qs_d = {qs_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qs_q  <= '0;
      bs_q  <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      dzn_q <= 1'b0;
    end else begin
      qs_q  <= qs_d;
      bs_q  <= bs_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      dzn_q <= dzn_d;
    end
  end

  // Result registers capture the post-iteration values on the final edge only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= w_last;
      if (w_last) begin
        quo_q <= qs_d;
        rem_q <= p_d;
        dz_q  <= dzn_q;
      end
    end
  end

  assign Q    = quo_q;
  assign R    = rem_q;
  assign dz   = dz_q;
  assign done = done_q;

endmodule

`default_nettype wire
